// File: rtl/mem_access.sv
// Memory-access pipeline stage: passes ALU results through, or runs one data-bus load/store per instruction.
// Latency: 1 cycle for non-memory ops and misaligned words; 1 + wait cycles for bus accesses.
// Backpressure: stall_req holds upstream from the accept cycle until ram_ready, or until the timeout cycle.
module mem_access #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [2:0]  mem_op,
  input  logic [31:0] result_in,
  input  logic [31:0] store_data,
  input  logic        write_reg_en_in,
  input  logic [4:0]  write_reg_addr_in,
  output logic        stall_req,
  output logic        ram_en,
  output logic [3:0]  ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  input  logic        ram_ready,
  output logic        valid_out,
  output logic [31:0] result_out,
  output logic        write_reg_en_out,
  output logic [4:0]  write_reg_addr_out,
  output logic        addr_err,
  output logic        bus_err
);

  localparam logic [2:0] OP_LW  = 3'd1;
  localparam logic [2:0] OP_LB  = 3'd2;
  localparam logic [2:0] OP_LBU = 3'd3;
  localparam logic [2:0] OP_SW  = 3'd4;
  localparam logic [2:0] OP_SB  = 3'd5;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [2:0]  op_q;
  logic [31:0] addr_q;
  logic        wen_q;
  logic [4:0]  waddr_q;
  logic [7:0]  wait_cnt;

  logic        is_mem;
  logic        is_word;
  logic        misaligned;
  logic        accept;
  logic        timeout;
  logic        store_q;
  logic [7:0]  lane_byte;
  logic [31:0] load_res;

  // Decode the presented instruction and the in-flight access
  always_comb begin
    is_mem     = (mem_op >= OP_LW) && (mem_op <= OP_SB);
    is_word    = (mem_op == OP_LW) || (mem_op == OP_SW);
    misaligned = is_word && (result_in[1:0] != 2'b00);
    accept     = (state == IDLE) && valid_in && is_mem && !misaligned;
    timeout    = (state == ACCESS) && !ram_ready && (32'(wait_cnt) == TIMEOUT_CYCLES);
    store_q    = (op_q == OP_SW) || (op_q == OP_SB);
    lane_byte  = 8'(ram_rdata >> {addr_q[1:0], 3'b000});
    case (op_q)
      OP_LW:   load_res = ram_rdata;
      OP_LB:   load_res = {{24{lane_byte[7]}}, lane_byte};
      OP_LBU:  load_res = {24'd0, lane_byte};
      default: load_res = addr_q;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // FSM next-state: leave ACCESS on completion or timeout
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ACCESS;
      ACCESS:  if (ram_ready || timeout) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM output: freeze upstream while an access is pending
  always_comb begin
    stall_req = 1'b0;
    if (rst) begin
      case (state)
        IDLE:    stall_req = accept;
        ACCESS:  stall_req = !ram_ready && !timeout;
        default: stall_req = 1'b0;
      endcase
    end
  end

  // Registered bus request, writeback bundle and access context
  always_ff @(posedge clk) begin
    if (!rst) begin
      ram_en             <= 1'b0;
      ram_we             <= 4'd0;
      ram_addr           <= 32'd0;
      ram_wdata          <= 32'd0;
      valid_out          <= 1'b0;
      result_out         <= 32'd0;
      write_reg_en_out   <= 1'b0;
      write_reg_addr_out <= 5'd0;
      addr_err           <= 1'b0;
      bus_err            <= 1'b0;
      op_q               <= 3'd0;
      addr_q             <= 32'd0;
      wen_q              <= 1'b0;
      waddr_q            <= 5'd0;
      wait_cnt           <= 8'd0;
    end else begin
      valid_out        <= 1'b0;
      write_reg_en_out <= 1'b0;
      addr_err         <= 1'b0;
      bus_err          <= 1'b0;
      case (state)
        IDLE: begin
          if (valid_in && !is_mem) begin
            valid_out          <= 1'b1;
            result_out         <= result_in;
            write_reg_en_out   <= write_reg_en_in;
            write_reg_addr_out <= write_reg_addr_in;
          end else if (valid_in && misaligned) begin
            valid_out          <= 1'b1;
            addr_err           <= 1'b1;
            result_out         <= result_in;
            write_reg_addr_out <= write_reg_addr_in;
          end else if (accept) begin
            op_q      <= mem_op;
            addr_q    <= result_in;
            wen_q     <= write_reg_en_in;
            waddr_q   <= write_reg_addr_in;
            wait_cnt  <= 8'd0;
            ram_en    <= 1'b1;
            ram_addr  <= {result_in[31:2], 2'b00};
            case (mem_op)
              OP_SW: begin
                ram_we    <= 4'b1111;
                ram_wdata <= store_data;
              end
              OP_SB: begin
                ram_we    <= 4'b0001 << result_in[1:0];
                ram_wdata <= {4{store_data[7:0]}};
              end
              default: ram_we <= 4'b0000;
            endcase
          end
        end
        ACCESS: begin
          if (ram_ready) begin
            ram_en             <= 1'b0;
            ram_we             <= 4'd0;
            valid_out          <= 1'b1;
            result_out         <= store_q ? addr_q : load_res;
            write_reg_en_out   <= store_q ? 1'b0 : wen_q;
            write_reg_addr_out <= waddr_q;
          end else if (timeout) begin
            ram_en             <= 1'b0;
            ram_we             <= 4'd0;
            valid_out          <= 1'b1;
            bus_err            <= 1'b1;
            result_out         <= addr_q;
            write_reg_addr_out <= waddr_q;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
